mem_req_ctrl: RTL
=================

// Module: mem_req_ctrl
// PURPOSE
// CPU-side initiator for the RAM handshake (MAR/enable/rnw/bus -> MBR/MFC).
// Takes one-shot read/write requests from the control unit and sequences one memory cycle.
// Holds enable until MFC rises, captures MBR on reads, then waits for MFC to fall.
// Reports done/err back to the control unit; sits between the control FSM and RAM.
// PARAMETERS
// ADDR_W   8   address width (MAR)
// DATA_W   8   data width (bus, MBR, rdata)
// TIMEOUT  16  max cycles waiting on an MFC edge before abort; must be >= 2
// CNT_W    5   timeout counter width; must hold TIMEOUT
// PORTS
// CLK        in   1       system clock, all state changes on posedge
// RST        in   1       synchronous, active-high reset
// req        in   1       start access; sampled only when busy=0
// req_rnw    in   1       1=read, 0=write
// req_addr   in   ADDR_W  access address
// req_wdata  in   DATA_W  write data
// busy       out  1       high from accepting req until the cycle done/err is asserted
// done       out  1       1-cycle pulse: access finished (also pulses on error)
// err        out  1       1-cycle pulse with done: access aborted on timeout
// rdata      out  DATA_W  read data; updated only on successful reads, held otherwise
// MAR        out  ADDR_W  address to RAM, stable for the whole access
// enable     out  1       access strobe to RAM
// rnw        out  1       direction to RAM, stable for the whole access
// bus        out  DATA_W  write data to RAM
// bus_oe     out  1       1 while driving bus (write accesses only, SETUP..RELEASE)
// MBR        in   DATA_W  RAM read data, valid while MFC=1
// MFC        in   1       RAM function complete; sampled at posedge CLK
// BEHAVIOUR
// Reset: state=IDLE; all outputs 0 (busy, done, err, rdata, MAR, enable, rnw, bus, bus_oe); counter 0.
// States: IDLE -> SETUP -> WAIT_MFC -> RELEASE -> IDLE.
// IDLE: if req, register MAR/rnw/bus, set busy and bus_oe=!req_rnw, go SETUP. done/err are 0.
// SETUP: 1 cycle of address/data setup; enable<=1; clear counter; go WAIT_MFC.
// WAIT_MFC: if MFC=1: on read rdata<=MBR; enable<=0; clear counter; go RELEASE.
//   Otherwise count; at count==TIMEOUT-1: enable<=0, latch err flag, go RELEASE.
// RELEASE: wait for MFC=0, then done<=1 (err<=flag), busy<=0, bus_oe<=0, go IDLE.
//   If MFC is still 1 after TIMEOUT cycles: done=err=1, go IDLE (stuck-MFC abort).
// Minimum latency: req sampled at edge k; enable rises at k+1; MFC seen at k+2; done=1 at k+3.
// Back-to-back: a new req is accepted in the cycle after done; no overlap with MFC high.
// enable never rises while MFC=1.
// MAR, rnw and bus change only in IDLE.
// req while busy=1 is ignored, not queued.
// Reset mid-access: enable, bus_oe, busy drop at that edge; no done pulse; rdata cleared.
// Counter saturates and never wraps; widths are fixed, with no arithmetic on data.
// STRUCTURE
// Shared package mem_pkg: state encoding (IDLE/SETUP/WAIT_MFC/RELEASE), ADDR_W/DATA_W defaults.
// Sub-module mem_timeout_ctr: clear/enable/expire counter; shared by WAIT_MFC and RELEASE.
// TESTING
// Read 0x01 with model RAM memo[1]=0x24 -> enable high 1 cycle after SETUP; rdata=0x24; done at k+3.
// Write 0x55 to addr 0x20 then read 0x20 -> bus_oe=1 only during write; rdata=0x55, err=0.
// MFC tied low, TIMEOUT=16 -> enable drops after 16 WAIT cycles; done=err=1; rdata unchanged.
// RST asserted in WAIT_MFC -> next edge enable=0, busy=0, no done; then a fresh read completes normally.
// req held high for 3 accesses (rd 0x08, wr 0x09, rd 0x08) -> 3 done pulses; req ignored while busy.
// MFC stuck high after a read -> RELEASE times out with done=err=1; next req waits for IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the CPU-side memory request controller.
package mem_pkg;

   localparam int ADDR_W_DEF  = 8;
   localparam int DATA_W_DEF  = 8;
   localparam int TIMEOUT_DEF = 16;
   localparam int CNT_W_DEF   = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETUP    = 2'd1,
      WAIT_MFC = 2'd2,
      RELEASE  = 2'd3
   } state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating cycle counter that flags when a wait on an MFC edge has run too long.
module mem_timeout_ctr
   import mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Stops at the last value so a long stall can never wrap back to zero.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_en && (count_q != LAST)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == LAST);

endmodule

// File: rtl/mem_req_ctrl.sv
// Sequences one RAM handshake (MAR/enable/rnw/bus -> MBR/MFC) per control-unit request,
// reporting done/err and aborting on a missing or stuck MFC edge.
module mem_req_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req,
   input  logic              req_rnw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] MAR,
   output logic              enable,
   output logic              rnw,
   output logic [DATA_W-1:0] bus,
   output logic              bus_oe,
   input  logic [DATA_W-1:0] MBR,
   input  logic              MFC
);

   state_e            state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              err_flag_q, err_flag_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic              enable_q, enable_d;
   logic              rnw_q, rnw_d;
   logic [DATA_W-1:0] bus_q, bus_d;
   logic              bus_oe_q, bus_oe_d;

   logic ctr_clear;
   logic ctr_en;
   logic ctr_expired;

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout (
      .clk      (CLK),
      .rst      (RST),
      .clear    (ctr_clear),
      .count_en (ctr_en),
      .expired  (ctr_expired)
   );

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_flag_d = err_flag_q;
      rdata_d    = rdata_q;
      mar_d      = mar_q;
      enable_d   = enable_q;
      rnw_d      = rnw_q;
      bus_d      = bus_q;
      bus_oe_d   = bus_oe_q;
      ctr_clear  = 1'b0;
      ctr_en     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               mar_d      = req_addr;
               rnw_d      = req_rnw;
               bus_d      = req_wdata;
               busy_d     = 1'b1;
               bus_oe_d   = ~req_rnw;
               err_flag_d = 1'b0;
               ctr_clear  = 1'b1;
               state_d    = SETUP;
            end
         end

         // Enable is held back while a previous access left MFC high.
         SETUP: begin
            if (MFC) begin
               if (ctr_expired) begin
                  done_d   = 1'b1;
                  err_d    = 1'b1;
                  busy_d   = 1'b0;
                  bus_oe_d = 1'b0;
                  state_d  = IDLE;
               end else begin
                  ctr_en = 1'b1;
               end
            end else begin
               enable_d  = 1'b1;
               ctr_clear = 1'b1;
               state_d   = WAIT_MFC;
            end
         end

         WAIT_MFC: begin
            if (MFC) begin
               if (rnw_q) begin
                  rdata_d = MBR;
               end
               enable_d  = 1'b0;
               ctr_clear = 1'b1;
               state_d   = RELEASE;
            end else if (ctr_expired) begin
               enable_d   = 1'b0;
               err_flag_d = 1'b1;
               ctr_clear  = 1'b1;
               state_d    = RELEASE;
            end else begin
               ctr_en = 1'b1;
            end
         end

         RELEASE: begin
            if (!MFC) begin
               done_d   = 1'b1;
               err_d    = err_flag_q;
               busy_d   = 1'b0;
               bus_oe_d = 1'b0;
               state_d  = IDLE;
            end else if (ctr_expired) begin
               done_d   = 1'b1;
               err_d    = 1'b1;
               busy_d   = 1'b0;
               bus_oe_d = 1'b0;
               state_d  = IDLE;
            end else begin
               ctr_en = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_flag_q <= 1'b0;
         rdata_q    <= '0;
         mar_q      <= '0;
         enable_q   <= 1'b0;
         rnw_q      <= 1'b0;
         bus_q      <= '0;
         bus_oe_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_flag_q <= err_flag_d;
         rdata_q    <= rdata_d;
         mar_q      <= mar_d;
         enable_q   <= enable_d;
         rnw_q      <= rnw_d;
         bus_q      <= bus_d;
         bus_oe_q   <= bus_oe_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign rdata  = rdata_q;
   assign MAR    = mar_q;
   assign enable = enable_q;
   assign rnw    = rnw_q;
   assign bus    = bus_q;
   assign bus_oe = bus_oe_q;

endmodule
